// File: rtl/mult_div_sequencer.sv
// Iterative unsigned MULTU/DIVU sequencer that owns the architectural HI/LO pair.
// It takes WIDTH cycles per multiply/divide and also handles MTHI/MTLO writes.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  // The accumulator's top bit is always zero between steps, so only WIDTH bits are kept.
  logic [WIDTH-1:0] acc, work, operand, hi, lo;
  logic [WIDTH-1:0] acc_next, work_next;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [CW-1:0]    count;
  logic             is_div, dbz, accept, last_step;

  assign accept    = start_i && (state != RUN);
  assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start_i) begin
          case (op_i)
            OP_MULTU: state_next = RUN;
            OP_DIVU:  state_next = (b_i == '0) ? DONE : RUN;
            default:  state_next = IDLE;
          endcase
        end
      end
      RUN:     if (count == CW'(WIDTH - 1)) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state == RUN);
    done_o        = (state == DONE);
    div_by_zero_o = (state == DONE) && dbz;
    hi_o          = hi;
    lo_o          = lo;
  end

  // The borrow out of the trial subtraction doubles as the "remainder < divisor" test.
  always_comb begin
    sum       = '0;
    shifted   = '0;
    diff      = '0;
    acc_next  = acc;
    work_next = work;
    if (is_div) begin
      shifted   = {acc, work[WIDTH-1]};
      diff      = shifted - {1'b0, operand};
      work_next = {work[WIDTH-2:0], ~diff[WIDTH]};
      acc_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end else begin
      sum       = {1'b0, acc} + (work[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      acc_next  = sum[WIDTH:1];
      work_next = {sum[0], work[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      work    <= '0;
      operand <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      is_div  <= 1'b0;
      dbz     <= 1'b0;
    end else if (accept) begin
      count <= '0;
      acc   <= '0;
      case (op_i)
        OP_MULTU: begin
          work    <= b_i;
          operand <= a_i;
          is_div  <= 1'b0;
        end
        OP_DIVU: begin
          work    <= a_i;
          operand <= b_i;
          is_div  <= 1'b1;
          if (b_i == '0) begin
            hi  <= a_i;
            lo  <= '1;
            dbz <= 1'b1;
          end
        end
        OP_MTHI: hi <= a_i;
        default: lo <= a_i;
      endcase
    end else if (state == RUN) begin
      acc   <= acc_next;
      work  <= work_next;
      count <= count + CW'(1);
      // HI/LO are committed only on the final step so they never expose partial results.
      if (last_step) begin
        hi  <= acc_next;
        lo  <= work_next;
        dbz <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: an arithmetic reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_mult_div_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start_i = 1'b0;
  logic [1:0]       op_i = 2'b00;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             busy_o, done_o, div_by_zero_o;
  logic [WIDTH-1:0] hi_o, lo_o;

  int compared = 0;
  int mismatched = 0;

  mult_div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Reference model: results come from plain * / %, with a cycle countdown for latency.
  logic [WIDTH-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic             m_done = 1'b0, m_dbz = 1'b0;
  int               remaining = 0;

  always @(posedge clk or negedge reset) begin
    logic [2*WIDTH-1:0] prod;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; remaining = 0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start_i) begin
        case (op_i)
          2'b00: begin
            prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
            p_hi = prod[2*WIDTH-1:WIDTH];
            p_lo = prod[WIDTH-1:0];
            remaining = WIDTH;
          end
          2'b01: begin
            if (b_i == 0) begin
              m_hi = a_i; m_lo = '1; m_done = 1'b1; m_dbz = 1'b1;
            end else begin
              p_hi = a_i % b_i;
              p_lo = a_i / b_i;
              remaining = WIDTH;
            end
          end
          2'b10: m_hi = a_i;
          default: m_lo = a_i;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cyc_busy", WIDTH'(busy_o), WIDTH'(remaining > 0));
    checkOutput("cyc_done", WIDTH'(done_o), WIDTH'(m_done));
    checkOutput("cyc_dbz",  WIDTH'(div_by_zero_o), WIDTH'(m_dbz));
    checkOutput("cyc_hi", hi_o, m_hi);
    checkOutput("cyc_lo", lo_o, m_lo);
  end

  // Drives one request across a single accepting edge; called at a negedge.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0; a_i = '0; b_i = '0;
  endtask

  task automatic waitDone(output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    while (!done_o && n < 100) begin
      if (busy_o) busy_cycles++;
      @(negedge clk);
      n++;
    end
    checkOutput("done_within_budget", WIDTH'(done_o), 32'd1);
  endtask

  initial begin
    int bc;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", WIDTH'(busy_o), 32'd0);
    checkOutput("reset_done", WIDTH'(done_o), 32'd0);
    checkOutput("reset_hi", hi_o, 32'd0);
    checkOutput("reset_lo", lo_o, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // MULTU full scale
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(bc);
    checkOutput("mul_full_hi", hi_o, 32'hFFFF_FFFE);
    checkOutput("mul_full_lo", lo_o, 32'h0000_0001);
    checkOutput("mul_full_busy_cycles", WIDTH'(bc), 32'd32);
    @(negedge clk);

    // DIVU 100/7 and 0x80000000/1
    applyStimulus(2'b01, 32'd100, 32'd7);
    waitDone(bc);
    checkOutput("div_100_7_lo", lo_o, 32'd14);
    checkOutput("div_100_7_hi", hi_o, 32'd2);
    @(negedge clk);
    applyStimulus(2'b01, 32'h8000_0000, 32'd1);
    waitDone(bc);
    checkOutput("div_msb_lo", lo_o, 32'h8000_0000);
    checkOutput("div_msb_hi", hi_o, 32'd0);
    @(negedge clk);

    // DIVU by zero
    applyStimulus(2'b01, 32'h1234, 32'd0);
    checkOutput("dbz_done", WIDTH'(done_o), 32'd1);
    checkOutput("dbz_flag", WIDTH'(div_by_zero_o), 32'd1);
    checkOutput("dbz_busy", WIDTH'(busy_o), 32'd0);
    checkOutput("dbz_hi", hi_o, 32'h1234);
    checkOutput("dbz_lo", lo_o, 32'hFFFF_FFFF);
    @(negedge clk);

    // MULTU 3x5 with an ignored mid-run DIVU, then back-to-back starts from DONE
    applyStimulus(2'b00, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    applyStimulus(2'b01, 32'd9, 32'd3);
    waitDone(bc);
    checkOutput("mul_3x5_hi", hi_o, 32'd0);
    checkOutput("mul_3x5_lo", lo_o, 32'd15);
    applyStimulus(2'b00, 32'd6, 32'd7);
    checkOutput("b2b_no_idle_busy", WIDTH'(busy_o), 32'd1);
    waitDone(bc);
    checkOutput("mul_6x7_lo", lo_o, 32'd42);
    applyStimulus(2'b01, 32'd5, 32'd0);
    checkOutput("b2b_dbz_done", WIDTH'(done_o), 32'd1);
    checkOutput("b2b_dbz_hi", hi_o, 32'd5);
    @(negedge clk);

    // MTHI / MTLO then MULTU 2x2
    applyStimulus(2'b10, 32'hAAAA_0000, 32'd0);
    checkOutput("mthi_hi", hi_o, 32'hAAAA_0000);
    applyStimulus(2'b11, 32'h5555, 32'd0);
    checkOutput("mtlo_lo", lo_o, 32'h5555);
    checkOutput("mtlo_done", WIDTH'(done_o), 32'd0);
    applyStimulus(2'b00, 32'd2, 32'd2);
    repeat (10) @(negedge clk);
    checkOutput("mul_2x2_mid_hi", hi_o, 32'hAAAA_0000);
    checkOutput("mul_2x2_mid_lo", lo_o, 32'h5555);
    waitDone(bc);
    checkOutput("mul_2x2_hi", hi_o, 32'd0);
    checkOutput("mul_2x2_lo", lo_o, 32'd4);
    @(negedge clk);

    // Reset in the middle of a MULTU
    applyStimulus(2'b00, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_mid_busy", WIDTH'(busy_o), 32'd0);
    checkOutput("rst_mid_hi", hi_o, 32'd0);
    checkOutput("rst_mid_lo", lo_o, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) bc++;
    end
    checkOutput("rst_no_done", WIDTH'(bc), 32'd0);
    applyStimulus(2'b01, 32'd100, 32'd7);
    waitDone(bc);
    checkOutput("rst_div_lo", lo_o, 32'd14);
    checkOutput("rst_div_hi", hi_o, 32'd2);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
